// File: rtl/para_def.sv
// para_def: shared constants, field offsets and types for the category-'a' message
package para_def;
  localparam int MSG_BYTES = 35;
  localparam int MSG_BITS = MSG_BYTES * 8;
  localparam logic [7:0] CATEGORY_A = 8'h61;
  localparam int PID_B = 0, PID_E = 0;
  localparam int CAT_B = 1, CAT_E = 1;
  localparam int TYPE_B = 2, TYPE_E = 2;
  localparam int SYM_B = 4, SYM_E = 8;
  localparam int EXP_B = 10, EXP_E = 12;
  localparam int SDEN_B = 13, SDEN_E = 13;
  localparam int STRK_B = 14, STRK_E = 17;
  localparam int VOL_B = 18, VOL_E = 21;
  localparam int PDEN_B = 22, PDEN_E = 22;
  localparam int PREM_B = 23, PREM_E = 26;
  localparam int TID_B = 27, TID_E = 30;
  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;
  typedef struct packed {
    logic [7:0]  pid;
    logic [7:0]  mtype;
    logic [39:0] symbol;
    logic [23:0] expiry;
    logic [7:0]  strike_den;
    logic [31:0] strike;
    logic [31:0] volume;
    logic [7:0]  prem_den;
    logic [31:0] premium;
    logic [31:0] trade_id;
  } fields_t;
  // Bit positions of a byte inside the MSB-first 280-bit word
  function automatic int hi(input int b);
    return MSG_BITS - 1 - 8 * b;
  endfunction
  function automatic int lo(input int b);
    return MSG_BITS - 8 - 8 * b;
  endfunction
endpackage

// File: rtl/stage2_a_field_reg.sv
// stage2_a_field_reg: one-entry valid/ready holding register for the decoded field bundle
//   i_load/i_fields: new field set; i_ready: consumer accept; o_valid/o_fields: held set
module stage2_a_field_reg
  import para_def::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    i_load,
  input  fields_t i_fields,
  input  logic    i_ready,
  output logic    o_valid,
  output fields_t o_fields
);
  logic    r_valid;
  fields_t r_fields;
  assign o_valid = r_valid;
  assign o_fields = r_fields;
  // A load only occurs when the slot is empty or draining, so it may overwrite
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_fields <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_fields <= i_fields;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/stage2_a_unpack.sv
// stage2_a_unpack: rebuilds the 35-byte category-'a' message and presents its fields
//   in_*: byte stream with sop/eop; out_*: field set (valid/ready); err_*: frame error
//   pulses; good_cnt/err_cnt: saturating delivered/dropped frame counters
module stage2_a_unpack
  import para_def::*;
#(
  parameter logic [7:0] CATEGORY = CATEGORY_A,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_sop,
  input  logic             in_eop,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_pid,
  output logic [7:0]       out_type,
  output logic [39:0]      out_symbol,
  output logic [23:0]      out_expiry,
  output logic [7:0]       out_strike_den,
  output logic [31:0]      out_strike,
  output logic [31:0]      out_volume,
  output logic [7:0]       out_prem_den,
  output logic [31:0]      out_premium,
  output logic [31:0]      out_trade_id,
  output logic             err_short,
  output logic             err_long,
  output logic             err_cat,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] err_cnt
);
  state_t              r_state;
  logic [5:0]          r_idx;
  logic [MSG_BITS-9:0] r_acc;
  logic                r_err_short, r_err_long, r_err_cat;
  logic [CNT_W-1:0]    r_good, r_err;
  logic [MSG_BITS-1:0] w_word;
  fields_t             w_fields, w_out;
  logic                w_acc, w_col, w_last, w_end, w_cat_ok, w_short, w_long, w_cat, w_load;
  logic                w_unused;
  assign in_ready = !out_valid || out_ready;
  assign w_acc = in_valid && in_ready;
  // sop always restarts, so only non-sop bytes continue a frame
  assign w_col = w_acc && !in_sop && r_state == COLLECT;
  assign w_last = r_idx == 6'(MSG_BYTES - 1);
  // The byte being accepted completes the word when it is byte 34
  assign w_word = {r_acc, in_data};
  assign w_end = w_col && in_eop && w_last;
  assign w_cat_ok = w_word[hi(CAT_B):lo(CAT_E)] == CATEGORY;
  assign w_short = w_col && in_eop && !w_last;
  assign w_long = w_col && !in_eop && w_last;
  assign w_cat = w_end && !w_cat_ok;
  assign w_load = w_end && w_cat_ok;
  assign w_fields.pid = w_word[hi(PID_B):lo(PID_E)];
  assign w_fields.mtype = w_word[hi(TYPE_B):lo(TYPE_E)];
  assign w_fields.symbol = w_word[hi(SYM_B):lo(SYM_E)];
  assign w_fields.expiry = w_word[hi(EXP_B):lo(EXP_E)];
  assign w_fields.strike_den = w_word[hi(SDEN_B):lo(SDEN_E)];
  assign w_fields.strike = w_word[hi(STRK_B):lo(STRK_E)];
  assign w_fields.volume = w_word[hi(VOL_B):lo(VOL_E)];
  assign w_fields.prem_den = w_word[hi(PDEN_B):lo(PDEN_E)];
  assign w_fields.premium = w_word[hi(PREM_B):lo(PREM_E)];
  assign w_fields.trade_id = w_word[hi(TID_B):lo(TID_E)];
  // Reserved bytes 3, 9 and 31-34 carry nothing
  assign w_unused = ^{w_word[hi(3):lo(3)], w_word[hi(9):lo(9)], w_word[hi(31):0]};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx <= '0;
      r_acc <= '0;
      r_err_short <= 1'b0;
      r_err_long <= 1'b0;
      r_err_cat <= 1'b0;
      r_good <= '0;
      r_err <= '0;
    end else begin
      r_err_short <= w_short;
      r_err_long <= w_long;
      r_err_cat <= w_cat;
      if (w_acc && in_sop) begin
        r_state <= COLLECT;
        r_idx <= 6'd1;
        r_acc <= {{(MSG_BITS - 16){1'b0}}, in_data};
      end else if (w_col) begin
        r_acc <= {r_acc[MSG_BITS-17:0], in_data};
        r_idx <= r_idx + 6'd1;
        r_state <= w_long ? DRAIN : in_eop ? IDLE : COLLECT;
      end else if (w_acc && in_eop && r_state == DRAIN) begin
        r_state <= IDLE;
      end
      if (w_load && !(&r_good)) r_good <= r_good + CNT_W'(1);
      if ((w_short || w_long || w_cat) && !(&r_err)) r_err <= r_err + CNT_W'(1);
    end
  end
  stage2_a_field_reg u_field_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_fields(w_fields),
    .i_ready (out_ready),
    .o_valid (out_valid),
    .o_fields(w_out)
  );
  assign out_pid = w_out.pid;
  assign out_type = w_out.mtype;
  assign out_symbol = w_out.symbol;
  assign out_expiry = w_out.expiry;
  assign out_strike_den = w_out.strike_den;
  assign out_strike = w_out.strike;
  assign out_volume = w_out.volume;
  assign out_prem_den = w_out.prem_den;
  assign out_premium = w_out.premium;
  assign out_trade_id = w_out.trade_id;
  assign err_short = r_err_short;
  assign err_long = r_err_long;
  assign err_cat = r_err_cat;
  assign good_cnt = r_good;
  assign err_cnt = r_err;
endmodule

// File: tb/tb_stage2_a_unpack.sv
// tb_stage2_a_unpack: randomized scenario bench for stage2_a_unpack against a frame-level model
module tb_stage2_a_unpack;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   in_data = 8'h00;
  logic         in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
  logic         in_ready, out_valid;
  logic         out_ready = 1'b1;
  logic [7:0]   out_pid, out_type, out_strike_den, out_prem_den;
  logic [39:0]  out_symbol;
  logic [23:0]  out_expiry;
  logic [31:0]  out_strike, out_volume, out_premium, out_trade_id;
  logic         err_short, err_long, err_cat;
  logic [15:0]  good_cnt, err_cnt;
  logic [223:0] dut_f;
  logic [7:0]   fb [0:63];
  logic         snap_ov, snap_es, snap_el, snap_ec;
  logic [223:0] snap_f;
  int           n_pass = 0, n_total = 0, exp_good = 0, exp_err = 0;

  always #5 clk = ~clk;

  stage2_a_unpack dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop),
    .in_eop(in_eop), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_pid(out_pid), .out_type(out_type), .out_symbol(out_symbol), .out_expiry(out_expiry),
    .out_strike_den(out_strike_den), .out_strike(out_strike), .out_volume(out_volume),
    .out_prem_den(out_prem_den), .out_premium(out_premium), .out_trade_id(out_trade_id),
    .err_short(err_short), .err_long(err_long), .err_cat(err_cat),
    .good_cnt(good_cnt), .err_cnt(err_cnt)
  );

  assign dut_f = {out_pid, out_type, out_symbol, out_expiry, out_strike_den, out_strike,
                  out_volume, out_prem_den, out_premium, out_trade_id};

  // Expected field set straight from the byte layout of the frame buffer
  function automatic logic [223:0] exp_f();
    return {fb[0], fb[2], fb[4], fb[5], fb[6], fb[7], fb[8], fb[10], fb[11], fb[12], fb[13],
            fb[14], fb[15], fb[16], fb[17], fb[18], fb[19], fb[20], fb[21], fb[22],
            fb[23], fb[24], fb[25], fb[26], fb[27], fb[28], fb[29], fb[30]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic build(input logic [7:0] cat);
    for (int i = 0; i < 64; i++) fb[i] = 8'($urandom);
    fb[1] = cat;
  endtask

  task automatic set32(input int at, input logic [31:0] v);
    for (int i = 0; i < 4; i++) fb[at + i] = v[31 - 8 * i -: 8];
  endtask

  task automatic put_byte(input logic [7:0] d, input logic s, input logic e);
    int t;
    t = 0;
    in_data = d;
    in_valid = 1'b1;
    in_sop = s;
    in_eop = e;
    while (!in_ready && t < 100) begin
      tick();
      t++;
    end
    if (t == 100) begin
      n_total++;
      $display("FAIL put_byte_timeout: in_ready=%b required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    in_sop = 1'b0;
    in_eop = 1'b0;
  endtask

  // Sends fb[s..n-1]; snapshots outputs after byte 34 or after an early last byte
  task automatic send_frame(input int s, input int n, input logic eop);
    for (int i = s; i < n; i++) begin
      put_byte(fb[i], i == 0, eop && i == n - 1);
      if (i == ((n < 35) ? n - 1 : 34)) begin
        snap_ov = out_valid;
        snap_es = err_short;
        snap_el = err_long;
        snap_ec = err_cat;
        snap_f = dut_f;
      end
    end
  endtask

  task automatic check_frame(input string name, input int n);
    logic g, es, el, ec;
    g = n == 35 && fb[1] == 8'h61;
    es = n < 35;
    el = n > 35;
    ec = n == 35 && !g;
    if (g) exp_good++;
    if (!g) exp_err++;
    n_total++;
    if (snap_ov !== g) $display("FAIL %s out_valid: got %b required %b", name, snap_ov, g);
    else n_pass++;
    n_total++;
    if ({snap_es, snap_el, snap_ec} !== {es, el, ec})
      $display("FAIL %s err_pulses: got %b%b%b required %b%b%b", name, snap_es, snap_el, snap_ec, es, el, ec);
    else n_pass++;
    if (g) begin
      n_total++;
      if (snap_f !== exp_f()) $display("FAIL %s fields: got %h required %h", name, snap_f, exp_f());
      else n_pass++;
    end
    n_total++;
    if (good_cnt !== 16'(exp_good)) $display("FAIL %s good_cnt: got %0d required %0d", name, good_cnt, exp_good);
    else n_pass++;
    n_total++;
    if (err_cnt !== 16'(exp_err)) $display("FAIL %s err_cnt: got %0d required %0d", name, err_cnt, exp_err);
    else n_pass++;
  endtask

  task automatic run_frame(input string name, input int n);
    send_frame(0, n, 1'b1);
    check_frame(name, n);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_total++;
    if ({out_valid, err_short, err_long, err_cat} !== 4'b0)
      $display("FAIL reset_flags: got %b required 0000", {out_valid, err_short, err_long, err_cat});
    else n_pass++;
    n_total++;
    if (dut_f !== 224'b0) $display("FAIL reset_fields: got %h required 0", dut_f);
    else n_pass++;
    n_total++;
    if ({good_cnt, err_cnt} !== 32'b0) $display("FAIL reset_counters: got %h required 0", {good_cnt, err_cnt});
    else n_pass++;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", in_ready);
    else n_pass++;
    rst_n = 1'b1;
    exp_good = 0;
    exp_err = 0;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      build(8'h61);
      fb[0] = 8'h41;
      set32(14, 32'h0001_86A0);
      set32(18, 32'd500);
      set32(27, 32'hDEAD_BEEF);
      run_frame("back_to_back", 35);
    end
  endtask

  task automatic test_stall();
    logic [223:0] f1;
    tick();
    out_ready = 1'b0;
    build(8'h61);
    run_frame("stall_first", 35);
    f1 = exp_f();
    build(8'h61);
    in_data = fb[0];
    in_valid = 1'b1;
    in_sop = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_total++;
      if (in_ready !== 1'b0) $display("FAIL stall_in_ready: got %b required 0", in_ready);
      else n_pass++;
      n_total++;
      if (out_valid !== 1'b1 || dut_f !== f1) $display("FAIL stall_hold: got %b/%h required 1/%h", out_valid, dut_f, f1);
      else n_pass++;
    end
    out_ready = 1'b1;
    tick();
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL stall_release: got %b required 0", out_valid);
    else n_pass++;
    send_frame(1, 35, 1'b1);
    check_frame("stall_second", 35);
  endtask

  task automatic test_short();
    tick();
    build(8'h61);
    run_frame("short", 21);
    tick();
    n_total++;
    if (err_short !== 1'b0) $display("FAIL short_pulse_end: got %b required 0", err_short);
    else n_pass++;
  endtask

  task automatic test_long();
    build(8'h61);
    run_frame("long", 40);
    build(8'h61);
    run_frame("after_long", 35);
  endtask

  task automatic test_bad_cat();
    build(8'h62);
    run_frame("bad_cat", 35);
  endtask

  task automatic test_reset_mid();
    build(8'h61);
    send_frame(0, 18, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_good = 0;
    exp_err = 0;
    n_total++;
    if ({out_valid, good_cnt, err_cnt} !== 33'b0)
      $display("FAIL reset_mid_state: got %h required 0", {out_valid, good_cnt, err_cnt});
    else n_pass++;
    build(8'h61);
    run_frame("reset_mid_full", 35);
  endtask

  task automatic test_restart();
    build(8'h61);
    send_frame(0, $urandom_range(30, 2), 1'b0);
    build(8'h61);
    run_frame("restart", 35);
  endtask

  task automatic test_random();
    int n;
    for (int k = 0; k < 24; k++) begin
      case ($urandom_range(3))
        0: n = $urandom_range(34, 2);
        1: n = $urandom_range(45, 36);
        default: n = 35;
      endcase
      build($urandom_range(3) == 0 ? 8'h62 : 8'h61);
      if ($urandom_range(3) == 0) put_byte(8'($urandom), 1'b0, 1'($urandom));
      run_frame("random", n);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_short();
    test_long();
    test_bad_cat();
    test_reset_mid();
    test_restart();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
